game_sequencer: RTL and testbench

- Game-flow controller for the breakout design, in the clk25 domain next to game and signal_generator.
- Sequences the game through attract, serve, play, miss, level-up and game-over phases.
- Debounces the fire button, and owns lives, level and BCD score.
- Gates the game datapath with run/hold/reload controls.

---
 rtl/game_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for breakout (clk25 domain).
// Sequences ATTRACT -> SERVE -> PLAY -> MISS / LEVEL_UP / GAME_OVER.
// It debounces the fire button, owns the lives, level and BCD score,
// and drives the run/hold/reload controls for the game datapath.
//
// Ports:
//   clk25          in   pixel clock
//   rst            in   synchronous active-high reset
//   frame_tick     in   one pulse per frame (start of vblank)
//   btn            in   fire button, active high
//   brick_hit      in   one pulse per destroyed brick
//   ball_lost      in   one pulse when the ball passes the paddle
//   bricks_cleared in   level: no bricks remain
//   state          out  0 ATTRACT,1 SERVE,2 PLAY,3 MISS,4 LEVEL_UP,5 GAME_OVER
//   run_en         out  ball motion enabled
//   ball_hold      out  ball locked to paddle
//   reload_bricks  out  one-cycle pulse to refill the brick map
//   lives          out  remaining lives
//   level          out  current level, 0-based, saturating at 7
//   score          out  4-digit packed BCD, saturating at 9999
//   paused         out  pause indicator
//
// Optional feature macro PAUSE_EN: when defined, a press in PLAY toggles
// pause (ball frozen, hits and losses ignored). When undefined, paused is 0.
// All timing parameters must lie in 1..255 (8-bit frame counter).

module game_sequencer #(
  parameter int LIVES_INIT      = 3,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int MISS_FRAMES     = 60,
  parameter int LEVEL_FRAMES    = 90,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn,
  input  logic        brick_hit,
  input  logic        ball_lost,
  input  logic        bricks_cleared,
  output logic [2:0]  state,
  output logic        run_en,
  output logic        ball_hold,
  output logic        reload_bricks,
  output logic [2:0]  lives,
  output logic [2:0]  level,
  output logic [15:0] score,
  output logic        paused
);

  typedef enum logic [2:0] {
    ST_ATTRACT   = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_MISS      = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_FRAMES - 1);
  localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
  localparam logic [7:0] LEVEL_LAST = 8'(LEVEL_FRAMES - 1);
  localparam logic [7:0] GO_LAST    = 8'(GAMEOVER_FRAMES - 1);
  localparam logic [2:0] LIVES_LD   = 3'(LIVES_INIT);

  // BCD increment with per-digit carry, saturating at 9999.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s == 16'h9999) return s;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] level_inc_sat(input logic [2:0] l);
    return (l == 3'd7) ? l : l + 3'd1;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [7:0]  db_cnt_q, db_cnt_d;
  logic        db_stable_q, db_stable_d;
  logic        db_arm_q, db_arm_d;
  logic        press_q, press_d;
  logic [2:0]  lives_q, lives_d;
  logic [2:0]  level_q, level_d;
  logic [15:0] score_q, score_d;
  logic        run_en_q, run_en_d;
  logic        ball_hold_q, ball_hold_d;
  logic        reload_q, reload_d;
  logic        paused_q, paused_d;
  logic        play_active;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    db_cnt_d    = db_cnt_q;
    db_stable_d = db_stable_q;
    db_arm_d    = db_arm_q;
    press_d     = 1'b0;
    lives_d     = lives_q;
    level_d     = level_q;
    score_d     = score_q;
    reload_d    = 1'b0;
    paused_d    = paused_q;
    play_active = 1'b1;

    // Debouncer: count consecutive frame samples that disagree with the
    // stable level. A press also needs the arm flag, which is only set once
    // a released level has been seen since reset, so a button held through
    // reset cannot start a game.
    if (frame_tick) begin
      if (btn == db_stable_q) begin
        db_cnt_d = 8'd0;
      end else if (db_cnt_q == DB_LAST) begin
        db_stable_d = btn;
        db_cnt_d    = 8'd0;
        press_d     = btn & db_arm_q;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
      if (!btn && !db_stable_q) db_arm_d = 1'b1;
    end

    case (state_q)
      ST_ATTRACT: begin
        if (press_q) begin
          state_d  = ST_SERVE;
          lives_d  = LIVES_LD;
          level_d  = 3'd0;
          score_d  = 16'h0000;
          reload_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (press_q) state_d = ST_PLAY;
      end
      ST_PLAY: begin
`ifdef PAUSE_EN
        play_active = ~paused_q;
        if (press_q) paused_d = ~paused_q;
`endif
        if (brick_hit && play_active) score_d = bcd_inc_sat(score_q);
        // A cleared board wins over a simultaneous loss: no life is taken.
        if (bricks_cleared) begin
          state_d  = ST_LEVEL_UP;
          level_d  = level_inc_sat(level_q);
          reload_d = 1'b1;
          fcnt_d   = 8'd0;
        end else if (ball_lost && play_active) begin
          fcnt_d = 8'd0;
          if (lives_q <= 3'd1) begin
            state_d = ST_GAME_OVER;
            lives_d = 3'd0;
          end else begin
            state_d = ST_MISS;
            lives_d = lives_q - 3'd1;
          end
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          fcnt_d = fcnt_q + 8'd1;
          if (fcnt_q == MISS_LAST) begin
            state_d = ST_SERVE;
            fcnt_d  = 8'd0;
          end
        end
      end
      ST_LEVEL_UP: begin
        if (frame_tick) begin
          fcnt_d = fcnt_q + 8'd1;
          if (fcnt_q == LEVEL_LAST) begin
            state_d = ST_SERVE;
            fcnt_d  = 8'd0;
          end
        end
      end
      ST_GAME_OVER: begin
        if (frame_tick) begin
          fcnt_d = fcnt_q + 8'd1;
          if (fcnt_q == GO_LAST) begin
            state_d = ST_ATTRACT;
            fcnt_d  = 8'd0;
          end
        end
      end
      default: state_d = ST_ATTRACT;
    endcase

    if (state_d != ST_PLAY) paused_d = 1'b0;
    // Outputs are registered from the next state so they line up with it.
    run_en_d    = (state_d == ST_PLAY) && !paused_d;
    ball_hold_d = (state_d == ST_SERVE);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q     <= ST_ATTRACT;
      fcnt_q      <= 8'd0;
      db_cnt_q    <= 8'd0;
      db_stable_q <= 1'b0;
      db_arm_q    <= 1'b0;
      press_q     <= 1'b0;
      lives_q     <= 3'd0;
      level_q     <= 3'd0;
      score_q     <= 16'h0000;
      run_en_q    <= 1'b0;
      ball_hold_q <= 1'b0;
      reload_q    <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      db_cnt_q    <= db_cnt_d;
      db_stable_q <= db_stable_d;
      db_arm_q    <= db_arm_d;
      press_q     <= press_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      score_q     <= score_d;
      run_en_q    <= run_en_d;
      ball_hold_q <= ball_hold_d;
      reload_q    <= reload_d;
      paused_q    <= paused_d;
    end
  end

  assign state         = state_q;
  assign run_en        = run_en_q;
  assign ball_hold     = ball_hold_q;
  assign reload_bricks = reload_q;
  assign lives         = lives_q;
  assign level         = level_q;
  assign score         = score_q;
  assign paused        = paused_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed scenarios with literal expectations
// followed by randomized play, all checked every cycle against a behavioural
// model of the game rules (integer score, countdown timers, sample history).

module tb_game_sequencer;

  localparam int LIVES_INIT = 3;
  localparam int DEB        = 3;
  localparam int MISS_F     = 60;
  localparam int LEVEL_F    = 90;
  localparam int GO_F       = 180;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn = 1'b0;
  logic        brick_hit = 1'b0;
  logic        ball_lost = 1'b0;
  logic        bricks_cleared = 1'b0;
  logic [2:0]  state;
  logic        run_en;
  logic        ball_hold;
  logic        reload_bricks;
  logic [2:0]  lives;
  logic [2:0]  level;
  logic [15:0] score;
  logic        paused;

  game_sequencer #(
    .LIVES_INIT(LIVES_INIT), .DEBOUNCE_FRAMES(DEB), .MISS_FRAMES(MISS_F),
    .LEVEL_FRAMES(LEVEL_F), .GAMEOVER_FRAMES(GO_F)
  ) dut (
    .clk25(clk25), .rst(rst), .frame_tick(frame_tick), .btn(btn),
    .brick_hit(brick_hit), .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
    .state(state), .run_en(run_en), .ball_hold(ball_hold),
    .reload_bricks(reload_bricks), .lives(lives), .level(level),
    .score(score), .paused(paused)
  );

  always #5 clk25 = ~clk25;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int reload_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 attract, 1 serve, 2 play, 3 miss, 4 level-up, 5 game-over.
  int m_state = 0, m_lives = 0, m_level = 0, m_score = 0, m_left = 0;
  bit m_run = 0, m_hold = 0, m_reload = 0, m_paused = 0;
  bit m_press = 0, m_stable = 0, m_armed = 0;
  bit m_hist[$];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_step();
    bit prs, flip, live_play;
    if (rst) begin
      m_state = 0; m_lives = 0; m_level = 0; m_score = 0; m_left = 0;
      m_run = 0; m_hold = 0; m_reload = 0; m_paused = 0;
      m_press = 0; m_stable = 0; m_armed = 0;
      m_hist.delete();
      return;
    end
    prs = m_press;
    m_press = 0;
    m_reload = 0;
    if (frame_tick) begin
      bit seen_release;
      seen_release = (btn == 1'b0) && (m_stable == 1'b0);
      m_hist.push_back(btn);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      // The level is accepted when the last DEB samples all disagree with it.
      flip = (m_hist.size() == DEB);
      foreach (m_hist[i]) if (m_hist[i] == m_stable) flip = 0;
      if (flip) begin
        m_stable = !m_stable;
        m_press = m_stable && m_armed;
      end
      if (seen_release) m_armed = 1;
    end
    case (m_state)
      0: if (prs) begin
           m_state = 1; m_lives = LIVES_INIT; m_level = 0; m_score = 0; m_reload = 1;
         end
      1: if (prs) m_state = 2;
      2: begin
           live_play = !m_paused;
`ifdef PAUSE_EN
           if (prs) m_paused = !m_paused;
`endif
           if (brick_hit && live_play && m_score < 9999) m_score++;
           if (bricks_cleared) begin
             m_state = 4; m_reload = 1; m_left = LEVEL_F;
             if (m_level < 7) m_level++;
           end else if (ball_lost && live_play) begin
             if (m_lives <= 1) begin
               m_lives = 0; m_state = 5; m_left = GO_F;
             end else begin
               m_lives--; m_state = 3; m_left = MISS_F;
             end
           end
         end
      3, 4, 5: if (frame_tick) begin
           m_left--;
           if (m_left == 0) m_state = (m_state == 5) ? 0 : 1;
         end
      default: m_state = 0;
    endcase
    if (m_state != 2) m_paused = 0;
    m_run = (m_state == 2) && !m_paused;
    m_hold = (m_state == 1);
  endtask

  initial forever begin
    @(posedge clk25);
    model_step();
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk25);
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_state));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("level", 32'(level), 32'(m_level));
      chk("score", 32'(score), 32'(to_bcd(m_score)));
      chk("run_en", 32'(run_en), 32'(m_run));
      chk("ball_hold", 32'(ball_hold), 32'(m_hold));
      chk("reload_bricks", 32'(reload_bricks), 32'(m_reload));
      chk("paused", 32'(paused), 32'(m_paused));
    end
    if (reload_bricks === 1'b1) reload_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic ft, input logic b, input logic bh, input logic bl, input logic bc);
    frame_tick = ft; btn = b; brick_hit = bh; ball_lost = bl; bricks_cleared = bc;
    @(negedge clk25);
  endtask

  task automatic frame(input logic b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    step(1'b0, b, 1'b0, 1'b0, 1'b0);
    step(1'b0, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n, input logic b);
    for (int i = 0; i < n; i++) frame(b);
  endtask

  task automatic do_press();
    frames(1, 1'b0);
    frames(DEB, 1'b1);
    frames(DEB, 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  logic b_lvl;

  initial begin
    @(negedge clk25);
    reset_dut();
    chk_en = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_run_en", 32'(run_en), 32'd0);

    // Two high samples then release: rejected.
    frames(1, 1'b0);
    frames(2, 1'b1);
    frames(DEB, 1'b0);
    chk("short_btn_state", 32'(state), 32'd0);

    // Three high samples: a press starts the game.
    reload_cnt = 0;
    frames(DEB, 1'b1);
    frames(DEB, 1'b0);
    chk("start_state", 32'(state), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_reloads", 32'(reload_cnt), 32'd1);
    chk("serve_hold", 32'(ball_hold), 32'd1);

    do_press();
    chk("play_state", 32'(state), 32'd2);
    chk("play_run_en", 32'(run_en), 32'd1);

    for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("score_99", 32'(score), 32'h0099);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("score_carry", 32'(score), 32'h0100);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("miss_state", 32'(state), 32'd3);
    chk("miss_lives", 32'(lives), 32'd2);
    frames(MISS_F - 1, 1'b0);
    chk("miss_hold_state", 32'(state), 32'd3);
    frame(1'b0);
    chk("miss_to_serve", 32'(state), 32'd1);

    // All three events in one cycle.
    do_press();
    reload_cnt = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("simul_score", 32'(score), 32'h0101);
    chk("simul_lives", 32'(lives), 32'd2);
    chk("simul_state", 32'(state), 32'd4);
    chk("simul_level", 32'(level), 32'd1);
    chk("simul_reload", 32'(reload_bricks), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("simul_reload_once", 32'(reload_cnt), 32'd1);
    frames(LEVEL_F - 1, 1'b0);
    chk("levelup_hold", 32'(state), 32'd4);
    frame(1'b0);
    chk("levelup_to_serve", 32'(state), 32'd1);

    // Reset mid-PLAY with score 0x0042 and two lives.
    reset_dut();
    do_press();
    do_press();
    for (int i = 0; i < 42; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(MISS_F, 1'b0);
    do_press();
    chk("pre_rst_state", 32'(state), 32'd2);
    chk("pre_rst_score", 32'(score), 32'h0042);
    chk("pre_rst_lives", 32'(lives), 32'd2);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_score", 32'(score), 32'h0);
    chk("midrst_lives", 32'(lives), 32'd0);
    chk("midrst_run_en", 32'(run_en), 32'd0);

    // Button held through reset must not start a game.
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    frames(DEB + 2, 1'b1);
    chk("held_thru_reset", 32'(state), 32'd0);
    frames(DEB + 1, 1'b0);
    do_press();
    chk("after_release_start", 32'(state), 32'd1);

    // Score saturation and running out of lives.
    do_press();
    for (int i = 0; i < 9999; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("score_9999", 32'(score), 32'h9999);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("score_sat", 32'(score), 32'h9999);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frames(MISS_F, 1'b0);
      do_press();
    end
    chk("last_life", 32'(lives), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gameover_lives", 32'(lives), 32'd0);
    chk("gameover_state", 32'(state), 32'd5);
    do_press();
    chk("gameover_ignores_press", 32'(state), 32'd5);
    frames(GO_F - 1 - (2 * DEB + 1), 1'b0);
    chk("gameover_hold", 32'(state), 32'd5);
    chk("gameover_score_held", 32'(score), 32'h9999);
    frame(1'b0);
    chk("gameover_to_attract", 32'(state), 32'd0);

    // Press while playing.
    do_press();
    do_press();
    do_press();
`ifdef PAUSE_EN
    chk("pause_on", 32'(paused), 32'd1);
    chk("pause_run_en", 32'(run_en), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pause_lives", 32'(lives), 32'd3);
    chk("pause_state", 32'(state), 32'd2);
    do_press();
    chk("pause_off", 32'(paused), 32'd0);
    chk("unpause_run_en", 32'(run_en), 32'd1);
`else
    chk("press_in_play_state", 32'(state), 32'd2);
    chk("press_in_play_run_en", 32'(run_en), 32'd1);
`endif

    // Randomized play.
    b_lvl = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(39) == 0) b_lvl = ~b_lvl;
      rst = ($urandom_range(2999) == 0);
      step($urandom_range(3) == 0, b_lvl, $urandom_range(3) == 0,
           $urandom_range(63) == 0, $urandom_range(127) == 0);
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
